// File: rtl/spi_slave_regs.sv
// SPI mode-0 slave register bank, all pins oversampled in the clk domain.
// Define SPI_SLAVE_READBACK_EN to return register contents on miso; otherwise miso is tied low.
module spi_slave_regs #(
   parameter int unsigned NSCRATCH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ss,
   input  logic        sclk,
   input  logic        mosi,
   output logic        miso,
   input  logic [15:0] gpio_in1,
   input  logic [15:0] gpio_in2,
   output logic [15:0] gpio_out1,
   output logic [15:0] gpio_out2,
   output logic        wr_stb,
   output logic        frame_err
);

   localparam int unsigned NS = (NSCRATCH > 0) ? NSCRATCH : 1;

   typedef enum logic [2:0] {StIdle, StCmd, StData, StWait, StErr} state_e;

   state_e state_q, state_d;
   logic [2:0] ss_sync, sclk_sync;
   logic [1:0] mosi_sync;
   logic [4:0] cnt_q, cnt_d;
   logic [7:0] cmd_q, cmd_d;
   logic [15:0] data_q, data_d;
   logic [15:0] out1_q, out1_d, out2_q, out2_d;
   logic [NS-1:0][15:0] scratch_q, scratch_d;
   logic wr_stb_q, wr_stb_d, frame_err_q, frame_err_d;
   logic load_rd;

   // Sync chains reset low so a held-low ss after reset cannot look like a fresh fall.
   logic ss_rise, ss_fall, sclk_rise, mosi_s;
   assign ss_rise   = ss_sync[1] & ~ss_sync[2];
   assign ss_fall   = ~ss_sync[1] & ss_sync[2];
   assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
   assign mosi_s    = mosi_sync[1];

   assign gpio_out1 = out1_q;
   assign gpio_out2 = out2_q;
   assign wr_stb    = wr_stb_q;
   assign frame_err = frame_err_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ss_sync     <= '0;
         sclk_sync   <= '0;
         mosi_sync   <= '0;
         state_q     <= StIdle;
         cnt_q       <= '0;
         cmd_q       <= '0;
         data_q      <= '0;
         out1_q      <= '0;
         out2_q      <= '0;
         scratch_q   <= '0;
         wr_stb_q    <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         ss_sync     <= {ss_sync[1:0], ss};
         sclk_sync   <= {sclk_sync[1:0], sclk};
         mosi_sync   <= {mosi_sync[0], mosi};
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cmd_q       <= cmd_d;
         data_q      <= data_d;
         out1_q      <= out1_d;
         out2_q      <= out2_d;
         scratch_q   <= scratch_d;
         wr_stb_q    <= wr_stb_d;
         frame_err_q <= frame_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cmd_d       = cmd_q;
      data_d      = data_q;
      out1_d      = out1_q;
      out2_d      = out2_q;
      scratch_d   = scratch_q;
      wr_stb_d    = 1'b0;
      frame_err_d = 1'b0;
      load_rd     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (ss_fall) begin
               state_d = StCmd;
               cnt_d   = '0;
            end
         end
         StCmd: begin
            if (ss_rise) begin
               frame_err_d = 1'b1;
               state_d     = StIdle;
            end else if (sclk_rise) begin
               cmd_d = {cmd_q[6:0], mosi_s};
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == 5'd7) begin
                  state_d = StData;
                  load_rd = 1'b1;
               end
            end
         end
         StData: begin
            if (ss_rise) begin
               frame_err_d = 1'b1;
               state_d     = StIdle;
            end else if (sclk_rise) begin
               data_d = {data_q[14:0], mosi_s};
               cnt_d  = cnt_q + 5'd1;
               if (cnt_q == 5'd23) state_d = StWait;
            end
         end
         StWait: begin
            if (ss_rise) begin
               state_d = StIdle;
               if (cmd_q[7]) begin
                  if (cmd_q[6:0] == 7'h00) begin
                     out1_d   = data_q;
                     wr_stb_d = 1'b1;
                  end
                  if (cmd_q[6:0] == 7'h01) begin
                     out2_d   = data_q;
                     wr_stb_d = 1'b1;
                  end
                  for (int unsigned i = 0; i < NSCRATCH; i++) begin
                     if (cmd_q[6:0] == 7'(4 + i)) begin
                        scratch_d[i] = data_q;
                        wr_stb_d     = 1'b1;
                     end
                  end
               end
            end else if (sclk_rise) begin
               state_d = StErr;
            end
         end
         StErr: begin
            if (ss_rise) begin
               frame_err_d = 1'b1;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

`ifdef SPI_SLAVE_READBACK_EN
   logic sclk_fall;
   logic [7:0] cmd_nx;
   logic [15:0] rd_word, rd_sr_q, rd_sr_d;
   logic miso_q, miso_d;

   assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
   assign cmd_nx    = {cmd_q[6:0], mosi_s};
   assign miso      = miso_q;

   // Read mux is evaluated with the command as it completes on the 8th rise.
   always_comb begin
      rd_word = '0;
      if (!cmd_nx[7]) begin
         case (cmd_nx[6:0])
            7'h00:   rd_word = out1_q;
            7'h01:   rd_word = out2_q;
            7'h02:   rd_word = gpio_in1;
            7'h03:   rd_word = gpio_in2;
            default: rd_word = '0;
         endcase
         for (int unsigned i = 0; i < NSCRATCH; i++) begin
            if (cmd_nx[6:0] == 7'(4 + i)) rd_word = scratch_q[i];
         end
      end
   end

   always_comb begin
      rd_sr_d = rd_sr_q;
      miso_d  = miso_q;
      if (load_rd) begin
         rd_sr_d = rd_word;
      end else if (state_q == StData && sclk_fall) begin
         miso_d  = rd_sr_q[15];
         rd_sr_d = {rd_sr_q[14:0], 1'b0};
      end
      if (state_d != StData) miso_d = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_sr_q <= '0;
         miso_q  <= 1'b0;
      end else begin
         rd_sr_q <= rd_sr_d;
         miso_q  <= miso_d;
      end
   end
`else
   logic unused_rd;
   assign unused_rd = ^{gpio_in1, gpio_in2, load_rd};
   assign miso      = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_regs.sv
// Directed bench for spi_slave_regs: bit-banged SPI frames against a register-map model,
// with expected read words queued at drive time and checked when the frame completes.
module tb_spi_slave_regs;

   logic        clk = 1'b0;
   logic        reset, ss, sclk, mosi, miso;
   logic [15:0] gpio_in1, gpio_in2, gpio_out1, gpio_out2;
   logic        wr_stb, frame_err;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [15:0] m_out1, m_out2;
   logic [15:0] m_scr [4];
   logic [15:0] rd_q [$];

   always #5 clk = ~clk;

   spi_slave_regs #(.NSCRATCH(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .ss        (ss),
      .sclk      (sclk),
      .mosi      (mosi),
      .miso      (miso),
      .gpio_in1  (gpio_in1),
      .gpio_in2  (gpio_in2),
      .gpio_out1 (gpio_out1),
      .gpio_out2 (gpio_out2),
      .wr_stb    (wr_stb),
      .frame_err (frame_err)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [15:0] model_rd(input logic [6:0] a);
      logic [15:0] r;
      r = 16'h0000;
`ifdef SPI_SLAVE_READBACK_EN
      case (a)
         7'h00: r = m_out1;
         7'h01: r = m_out2;
         7'h02: r = gpio_in1;
         7'h03: r = gpio_in2;
         7'h04, 7'h05, 7'h06, 7'h07: r = m_scr[a - 7'h04];
         default: r = 16'h0000;
      endcase
`else
      if (a == 7'h7F) r = 16'h0000;
`endif
      return r;
   endfunction

   // Sends nbits of v (MSB first, taken from v[nbits-1:0]) and checks the aftermath.
   task automatic frame(input string tag, input logic [24:0] v, input int nbits, input int gap);
      logic [7:0]  cmd;
      logic [15:0] data, rd_word, exp_rd;
      logic        cmd_miso;
      bit          commit, exp_err;
      int          stb_n, err_n, stb_at, err_at;
      cmd = v[23:16];
      data = v[15:0];
      rd_word = 16'h0000;
      cmd_miso = 1'b0;
      stb_n = 0; err_n = 0; stb_at = 0; err_at = 0;
      exp_err = (nbits != 24);
      commit = !exp_err && cmd[7] && (cmd[6:0] < 7'h02 ||
               (cmd[6:0] >= 7'h04 && cmd[6:0] < 7'h08));
      if (nbits == 24) begin
         exp_rd = cmd[7] ? 16'h0000 : model_rd(cmd[6:0]);
         rd_q.push_back(exp_rd);
      end
      ss = 1'b0;
      wait_clk(5);
      for (int i = 0; i < nbits; i++) begin
         mosi = v[nbits-1-i];
         wait_clk(5);
         if (i < 8) cmd_miso |= miso;
         else if (i < 24) rd_word[23-i] = miso;
         sclk = 1'b1;
         wait_clk(5);
         sclk = 1'b0;
      end
      wait_clk(5);
      ss = 1'b1;
      for (int e = 1; e <= gap; e++) begin
         @(posedge clk);
         #1;
         if (wr_stb) begin stb_n++; stb_at = e; end
         if (frame_err) begin err_n++; err_at = e; end
      end
      @(negedge clk);
      if (commit) begin
         if (cmd[6:0] == 7'h00) m_out1 = data;
         else if (cmd[6:0] == 7'h01) m_out2 = data;
         else m_scr[cmd[6:0] - 7'h04] = data;
      end
      chk({tag, " wr_stb count"}, stb_n, {31'd0, commit});
      chk({tag, " frame_err count"}, err_n, {31'd0, exp_err});
      if (commit) chk({tag, " wr_stb edge"}, stb_at, 3);
      if (exp_err) chk({tag, " frame_err edge"}, err_at, 3);
      chk({tag, " gpio_out1"}, {16'h0, gpio_out1}, {16'h0, m_out1});
      chk({tag, " gpio_out2"}, {16'h0, gpio_out2}, {16'h0, m_out2});
      if (nbits >= 8) chk({tag, " miso in cmd"}, {31'd0, cmd_miso}, 0);
      if (nbits == 24) chk({tag, " read word"}, {16'h0, rd_word}, {16'h0, rd_q.pop_front()});
   endtask

   initial begin
      int err_seen;
      reset = 1'b1; ss = 1'b1; sclk = 1'b0; mosi = 1'b0;
      gpio_in1 = 16'h0000; gpio_in2 = 16'h0000;
      m_out1 = 16'h0000; m_out2 = 16'h0000;
      for (int i = 0; i < 4; i++) m_scr[i] = 16'h0000;
      wait_clk(3);
      chk("reset gpio_out1", {16'h0, gpio_out1}, 0);
      chk("reset gpio_out2", {16'h0, gpio_out2}, 0);
      chk("reset miso", {31'd0, miso}, 0);
      chk("reset wr_stb", {31'd0, wr_stb}, 0);
      chk("reset frame_err", {31'd0, frame_err}, 0);
      reset = 1'b0;
      wait_clk(3);

      frame("wr80", {1'b0, 8'h80, 16'h1234}, 24, 6);
      frame("wr81", {1'b0, 8'h81, 16'hBEEF}, 24, 6);

      // Reset in the middle of a frame, with ss still low at release.
      ss = 1'b0;
      wait_clk(5);
      repeat (3) begin
         mosi = 1'b1; wait_clk(5); sclk = 1'b1; wait_clk(5); sclk = 1'b0;
      end
      wait_clk(2);
      reset = 1'b1;
      #1;
      m_out1 = 16'h0000; m_out2 = 16'h0000;
      for (int i = 0; i < 4; i++) m_scr[i] = 16'h0000;
      chk("midreset gpio_out1", {16'h0, gpio_out1}, 0);
      chk("midreset gpio_out2", {16'h0, gpio_out2}, 0);
      chk("midreset miso", {31'd0, miso}, 0);
      chk("midreset wr_stb", {31'd0, wr_stb}, 0);
      chk("midreset frame_err", {31'd0, frame_err}, 0);
      wait_clk(3);
      reset = 1'b0;
      wait_clk(5);
      ss = 1'b1;
      err_seen = 0;
      for (int e = 0; e < 6; e++) begin
         @(posedge clk);
         #1;
         if (frame_err || wr_stb) err_seen++;
      end
      @(negedge clk);
      chk("stale ss release quiet", err_seen, 0);
      frame("ss only", 25'h0, 0, 6);

      frame("rewr80", {1'b0, 8'h80, 16'h1234}, 24, 6);
      frame("wr2A", {1'b0, 8'hAA, 16'hAAAB}, 24, 6);
      frame("rd2A", {1'b0, 8'h2A, 16'h0000}, 24, 6);
      gpio_in1 = 16'hA5C3;
      frame("rd02", {1'b0, 8'h02, 16'h0000}, 24, 6);
      gpio_in2 = 16'h3C96;
      frame("rd03", {1'b0, 8'h03, 16'hFFFF}, 24, 6);
      frame("wr84", {1'b0, 8'h84, 16'h5555}, 24, 6);
      frame("rd04", {1'b0, 8'h04, 16'h0000}, 24, 6);
      frame("wr87", {1'b0, 8'h87, 16'h0F0F}, 24, 6);
      frame("rd07", {1'b0, 8'h07, 16'h0000}, 24, 6);
      frame("rd00", {1'b0, 8'h00, 16'h0000}, 24, 6);
      frame("wr88", {1'b0, 8'h88, 16'h7E7E}, 24, 6);
      frame("rd08", {1'b0, 8'h08, 16'h0000}, 24, 6);
      frame("short20", {1'b0, 8'h80, 16'h9999} >> 4, 20, 6);
      frame("long25", {8'h80, 16'h7777, 1'b1}, 25, 6);
      frame("b2b first", {1'b0, 8'h80, 16'h0001}, 24, 4);
      frame("b2b second", {1'b0, 8'h80, 16'h0002}, 24, 4);
      chk("final gpio_out1", {16'h0, gpio_out1}, 32'h0002);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_slave_regs.md
# spi_slave_regs

SPI slave register bank that sits directly downstream of the MCU's `spi_master` on the `ss`/`sclk`/`mosi`/`miso` wires. It decodes 24-bit frames made of an 8-bit command/address followed by 16-bit data, and writes or reads a small register map. The map exposes two 16-bit GPIO output registers, two GPIO input ports, and scratch registers. All SPI pins are oversampled in the single system clock domain; there is no logic clocked by `sclk`.

## Interface
- `NSCRATCH`, 4: number of 16-bit scratch registers at addresses 0x04..0x04+NSCRATCH-1; legal range 0..8.
- `clk` input 1: system clock, rising-edge.
- `reset` input 1: asynchronous, active-high reset.
- `ss` input 1: SPI slave select, active-low, asynchronous to `clk`.
- `sclk` input 1: SPI clock, idle low, asynchronous to `clk`.
- `mosi` input 1: SPI data in, asynchronous to `clk`.
- `miso` output 1: SPI data out.
- `gpio_in1` input 16: read-only port, address 0x02.
- `gpio_in2` input 16: read-only port, address 0x03.
- `gpio_out1` output 16: RW register, address 0x00.
- `gpio_out2` output 16: RW register, address 0x01.
- `wr_stb` output 1: one-`clk` pulse when a write commits to a writable register.
- `frame_err` output 1: one-`clk` pulse when a frame is discarded.

## Operation
- **Protocol:** SPI mode 0 (CPOL=0, CPHA=0), MSB first.
  - Frame = cmd[7:0] then data[15:0], 24 bits in total.
  - cmd[7] = 1 is a write; 0 is a read. cmd[6:0] is the register address.
- **Synchronizers:** `ss`, `sclk` and `mosi` each pass through a 2-FF synchronizer. A third register on `sclk` and `ss` is used for edge detection.
- **Sampling and driving:** `mosi` is sampled on each detected `sclk` rise. `miso` changes on each detected `sclk` fall.
- **Bit counter:** 5 bits; cleared on the `ss` falling edge.
- **States:**
  - IDLE: `ss` high. Waits for `ss` fall, then goes to CMD.
  - CMD: 8 rises shift in cmd. On the 8th rise, latch the address, capture read data into the output shift register, then go to DATA.
  - DATA: 16 rises shift in data. After the 24th rise, go to WAIT.
  - WAIT: waits for `ss` rise.
    - A 25th `sclk` rise goes to ERR.
    - On `ss` rise: if cmd is a write to address 0x00, 0x01 or a valid scratch address, commit the data and pulse `wr_stb`. Go to IDLE.
  - ERR: waits for `ss` rise, pulses `frame_err`, then goes to IDLE. No commit.
- **Short frame:** `ss` rises in CMD or DATA (fewer than 24 bits). Pulse `frame_err`, go to IDLE, no register change.
- **Ignored writes:** writes to RO or unmapped addresses are silently ignored (no `wr_stb`, no `frame_err`).
- **Read data:**
  - Reads of unmapped addresses return 0x0000.
  - `gpio_in1` and `gpio_in2` are sampled at the 8th rise; no further synchronization is applied.
- **`miso` behaviour:** driven 0 during CMD. During DATA it carries read data bit 15 first; the first bit is presented on the 8th `sclk` fall. Driven 0 in IDLE, WAIT and ERR. Write frames return 0x0000 on `miso`.
- **Reset:** asynchronous assert sets:
  - `gpio_out1` = `gpio_out2` = 0x0000, all scratch = 0x0000.
  - `miso` = 0, `wr_stb` = 0, `frame_err` = 0.
  - State = IDLE.
- **Reset mid-frame:** the frame is abandoned. After release the block stays in IDLE until a fresh `ss` fall is seen.

## Timing
- **Input constraint:** `sclk` high and low phases are each ≥ 4 `clk` periods. `ss` setup to the first `sclk` rise and hold after the last `sclk` fall are each ≥ 4 `clk` periods.
- **Pin-to-detect latency:** 3 `clk` rising edges from a pin transition to the detected edge.
- **Write commit:** `gpio_out1`/`gpio_out2` update, and `wr_stb` pulses, on the same `clk` edge, 3 `clk` edges after the `ss` pin rises.
- **`miso` valid:** ≤ 4 `clk` after the `sclk` pin falls, which leaves ≥ 0 `clk` margin to the next `sclk` rise.
- **Frame error:** `frame_err` pulses on the `clk` edge where the `ss` rise is detected.
- **Back-to-back frames:** frames are accepted with `ss` high for ≥ 4 `clk`. The commit of frame N precedes the first sample of frame N+1.

## Configuration
- **`SPI_SLAVE_READBACK_EN` defined:** read frames return register contents on `miso` as described above.
- **`SPI_SLAVE_READBACK_EN` undefined:**
  - The read shift register and read mux are removed, and `miso` is tied to 0.
  - Read frames complete normally with no side effects.

## Test plan
- Reset asserted mid-operation: all outputs 0, `gpio_out1`=`gpio_out2`=0x0000. After release, an `ss` high→low→high with no `sclk` gives a `frame_err` pulse and no write.
- Write cmd 0x80, data 0x1234, then cmd 0x81, data 0xBEEF → `gpio_out1`=0x1234, `gpio_out2`=0xBEEF, two `wr_stb` pulses, each 3 `clk` after the `ss` rise.
- Write cmd 0xAA (address 0x2A, unmapped), data 0xAAAB → outputs unchanged, no `wr_stb`, no `frame_err`. A following read of 0x2A returns 0x0000.
- With `gpio_in1`=0xA5C3: read cmd 0x02 → `miso` shifts 0xA5C3 MSB first during the data phase. Write 0x84=0x5555, then read 0x04 → 0x5555 (readback-enabled build); all zeros when the macro is undefined.
- Short frame of 20 bits (cmd 0x80) and long frame of 25 bits → `frame_err` pulses once each, `gpio_out1` unchanged.
- Back-to-back writes 0x80=0x0001, then 0x80=0x0002 with `ss` high for 4 `clk` → final `gpio_out1`=0x0002, two `wr_stb` pulses.
